// File: rtl/alu_pkg.sv
// Shared types for the round-robin ALU scheduler: operand width, opcodes and FSM states.
package alu_pkg;

    localparam int W = 4;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_CMP = 2'b10,
        OP_AND = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: add / sub / compare / and on the latched operands of the scheduler.
module alu_core #(
    parameter int W = alu_pkg::W
) (
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W:0]   result,
    output logic         eq,
    output logic         gt,
    output logic         lt
);
    import alu_pkg::*;

    logic [W-1:0] diff;

    always_comb begin
        result = '0;
        eq     = 1'b0;
        gt     = 1'b0;
        lt     = 1'b0;
        diff   = a - b;
        case (op_t'(op))
            OP_ADD: result = {1'b0, a} + {1'b0, b};
            // Top bit is a "no borrow" flag rather than a sign bit.
            OP_SUB: result = {(a >= b), diff};
            OP_CMP: begin
                eq = (a == b);
                gt = (a > b);
                lt = (a < b);
            end
            OP_AND: result = {1'b0, a & b};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Two-requester round-robin scheduler around a shared ALU: grant, execute, then one-cycle done pulse.
module alu_rr_scheduler #(
    parameter int W = alu_pkg::W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0,
    input  logic         req1,
    input  logic [1:0]   op0,
    input  logic [1:0]   op1,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    output logic [1:0]   done,
    output logic [W:0]   result,
    output logic         eq,
    output logic         gt,
    output logic         lt,
    output logic         busy,
    output logic         grant_id
);
    import alu_pkg::*;

    state_t       state, state_nxt;
    logic         ptr, ptr_nxt;
    logic         winner;
    logic         take;

    logic [1:0]   op_p0;
    logic [W-1:0] a_p0, b_p0;

    logic [W:0]   core_result;
    logic         core_eq, core_gt, core_lt;

    // Pointer only matters on contention; a sole requester always wins.
    assign winner = (req0 && req1) ? ptr : req1;

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        take      = 1'b0;
        done      = 2'b00;
        case (state)
            ST_IDLE: begin
                if (req0 || req1) begin
                    take      = 1'b1;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: state_nxt = ST_DONE;
            ST_DONE: begin
                done      = grant_id ? 2'b10 : 2'b01;
                ptr_nxt   = ~grant_id;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ptr      <= 1'b0;
            grant_id <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            if (take) grant_id <= winner;
        end
    end

    // Stage p0: capture the winner's operands; later input changes cannot disturb the operation.
    always_ff @(posedge clk) begin
        if (take) begin
            op_p0 <= winner ? op1 : op0;
            a_p0  <= winner ? a1  : a0;
            b_p0  <= winner ? b1  : b0;
        end
    end

    alu_core #(.W(W)) u_core (
        .op     (op_p0),
        .a      (a_p0),
        .b      (b_p0),
        .result (core_result),
        .eq     (core_eq),
        .gt     (core_gt),
        .lt     (core_lt)
    );

    // Stage p1: results update only in EXEC and hold until the next operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result <= '0;
            eq     <= 1'b0;
            gt     <= 1'b0;
            lt     <= 1'b0;
        end else if (state == ST_EXEC) begin
            result <= core_result;
            eq     <= core_eq;
            gt     <= core_gt;
            lt     <= core_lt;
        end
    end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler: directed scenarios plus random traffic against a transaction-level model.
module tb_alu_rr_scheduler;

    logic       clk;
    logic       rst_n;
    logic       req0, req1;
    logic [1:0] op0, op1;
    logic [3:0] a0, b0, a1, b1;
    logic [1:0] done;
    logic [4:0] result;
    logic       eq, gt, lt;
    logic       busy;
    logic       grant_id;

    int vectors;
    int miscompares;

    // Model: phase of current transaction (0 idle, 1 executing, 2 completing)
    int m_phase;
    int m_ptr;
    int m_gid;
    int m_op, m_a, m_b;
    int m_res;
    int m_flags;

    alu_rr_scheduler #(.W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (req0),
        .req1     (req1),
        .op0      (op0),
        .op1      (op1),
        .a0       (a0),
        .b0       (b0),
        .a1       (a1),
        .b1       (b1),
        .done     (done),
        .result   (result),
        .eq       (eq),
        .gt       (gt),
        .lt       (lt),
        .busy     (busy),
        .grant_id (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void ref_alu(input int op, input int a, input int b,
                                    output int res, output int flags);
        res   = 0;
        flags = 0;
        case (op)
            0: res = a + b;
            1: res = ((a - b + 16) % 16) + ((a >= b) ? 16 : 0);
            2: flags = (a == b) ? 4 : ((a > b) ? 2 : 1);
            default: res = a & b;
        endcase
    endfunction

    task automatic model_step();
        int w;
        if (!rst_n) begin
            m_phase = 0;
            m_ptr   = 0;
            m_gid   = 0;
            m_res   = 0;
            m_flags = 0;
        end else if (m_phase == 0) begin
            if (req0 || req1) begin
                if (req0 && req1) w = m_ptr;
                else              w = req1 ? 1 : 0;
                m_gid   = w;
                m_op    = (w == 1) ? int'(op1) : int'(op0);
                m_a     = (w == 1) ? int'(a1)  : int'(a0);
                m_b     = (w == 1) ? int'(b1)  : int'(b0);
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            ref_alu(m_op, m_a, m_b, m_res, m_flags);
            m_phase = 2;
        end else begin
            m_ptr   = 1 - m_gid;
            m_phase = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("done",     32'(done),     (m_phase == 2) ? ((m_gid == 1) ? 32'd2 : 32'd1) : 32'd0);
        chk("result",   32'(result),   32'(m_res));
        chk("flags",    32'({eq, gt, lt}), 32'(m_flags));
        chk("busy",     32'(busy),     (m_phase != 0) ? 32'd1 : 32'd0);
        chk("grant_id", 32'(grant_id), 32'(m_gid));
    endtask

    task automatic run_op(input string tag, input int who, input logic [1:0] op,
                          input logic [3:0] a, input logic [3:0] b,
                          input logic [4:0] exp_res, input logic [2:0] exp_flags);
        req0 = (who == 0);
        req1 = (who == 1);
        if (who == 0) begin op0 = op; a0 = a; b0 = b; end
        else          begin op1 = op; a1 = a; b1 = b; end
        tick();
        tick();
        chk({tag, "_done"},  32'(done),  (who == 1) ? 32'd2 : 32'd1);
        chk({tag, "_res"},   32'(result), 32'(exp_res));
        chk({tag, "_flags"}, 32'({eq, gt, lt}), 32'(exp_flags));
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
    endtask

    initial begin
        int pulses;
        logic [1:0] seq [4];

        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        op0 = 2'd0;  op1 = 2'd0;
        a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0;
        m_phase = 0; m_ptr = 0; m_gid = 0; m_op = 0; m_a = 0; m_b = 0;
        m_res = 0; m_flags = 0;

        @(negedge clk);
        tick();
        tick();
        chk("rst_done",  32'(done),   32'd0);
        chk("rst_res",   32'(result), 32'd0);
        chk("rst_busy",  32'(busy),   32'd0);
        rst_n = 1'b1;
        tick();

        run_op("add98",  0, 2'b00, 4'd9,  4'd8,  5'b10001, 3'b000);
        run_op("sub35",  1, 2'b01, 4'd3,  4'd5,  5'b01110, 3'b000);
        run_op("sub53",  1, 2'b01, 4'd5,  4'd3,  5'b10010, 3'b000);
        run_op("cmp77",  0, 2'b10, 4'd7,  4'd7,  5'd0,     3'b100);
        run_op("cmp92",  0, 2'b10, 4'd9,  4'd2,  5'd0,     3'b010);
        run_op("cmp29",  1, 2'b10, 4'd2,  4'd9,  5'd0,     3'b001);
        run_op("and",    0, 2'b11, 4'd12, 4'd10, 5'd8,     3'b000);
        run_op("add_ff", 1, 2'b00, 4'd15, 4'd15, 5'd30,    3'b000);

        // Reset while an operation is executing
        req1 = 1'b1; op1 = 2'b00; a1 = 4'd6; b1 = 4'd7;
        tick();
        chk("abort_busy", 32'(busy), 32'd1);
        rst_n = 1'b0; req1 = 1'b0;
        tick();
        chk("abort_done", 32'(done),   32'd0);
        chk("abort_res",  32'(result), 32'd0);
        chk("abort_gid",  32'(grant_id), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("abort_nopulse", 32'(done), 32'd0);
        req0 = 1'b1; req1 = 1'b1; op0 = 2'b11; a0 = 4'd5; b0 = 4'd3;
        tick();
        chk("abort_regrant", 32'(grant_id), 32'd0);
        tick();
        req0 = 1'b0; req1 = 1'b0;
        tick();

        // Winner changes operands and drops its request mid-operation
        req0 = 1'b1; op0 = 2'b00; a0 = 4'd3; b0 = 4'd4;
        tick();
        a0 = 4'd15; req0 = 1'b0;
        tick();
        chk("drop_done", 32'(done),   32'd1);
        chk("drop_res",  32'(result), 32'd7);
        tick();

        // Both requesters held from reset
        rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1;
        op0 = 2'b00; a0 = 4'd1; b0 = 4'd1;
        op1 = 2'b11; a1 = 4'd7; b1 = 4'd3;
        tick();
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done != 2'b00) begin
                if (pulses < 4) seq[pulses] = done;
                pulses++;
            end
        end
        chk("rr_pulses", 32'(pulses), 32'd4);
        chk("rr_seq", {24'd0, seq[0], seq[1], seq[2], seq[3]}, {24'd0, 2'b01, 2'b10, 2'b01, 2'b10});
        req0 = 1'b0; req1 = 1'b0;
        tick();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            req0  = ($urandom_range(0, 2) != 0);
            req1  = ($urandom_range(0, 2) != 0);
            op0   = 2'($urandom_range(0, 3));
            op1   = 2'($urandom_range(0, 3));
            a0    = 4'($urandom_range(0, 15));
            b0    = 4'($urandom_range(0, 15));
            a1    = 4'($urandom_range(0, 15));
            b1    = 4'($urandom_range(0, 15));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
